generic_bus_ram_responder: RTL and testbench
============================================

Name: generic_bus_ram_responder

Overview:
Responder (slave) end of generic_bus_if. It services ren/wen/addr/wdata/byte_en requests issued by the pipeline memory stage's data port or the fetch port. It returns rdata and the busy handshake after a programmable number of wait states, backed by a word-organised byte-writable RAM. It serves as the data/instruction memory model for pipeline simulation and as the template for on-chip scratchpad responders.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, min 4.
LATENCY, 2, cycles from request acceptance to response; min 1, max 15.
OOR_RDATA, 32'hBAD0_BAD0, rdata returned for an out-of-range read.

Ports:
CLK  in  1  clock, all logic on rising edge.
RST  in  1  synchronous active-high reset.
addr  in  32  byte address from initiator.
wdata  in  32  write data, lane-replicated by initiator.
ren  in  1  read request.
wen  in  1  write request.
byte_en  in  4  lane enables; bit i gates bits [8i+7:8i].
rdata  out  32  read data, valid only in the cycle busy is 0.
busy  out  1  high except the single completion cycle.
err  out  1  one-cycle pulse coincident with completion of an out-of-range or ren&wen request.
rd_count  out  16  completed reads, saturating.
wr_count  out  16  completed writes, saturating.

Behaviour:
- Reset (RST high at a clock edge): state IDLE, busy=1, rdata=0, err=0, rd_count=0, wr_count=0, wait counter=0. RAM contents are not cleared. Reset during WAIT aborts the transaction with no write.
- Word index = addr[log2(DEPTH)+1:2]. addr[1:0] is ignored; alignment is the initiator's job. The address is out of range if any addr bit above log2(DEPTH)+1 is set.
- FSM states: IDLE, WAIT, RESP.
- IDLE: busy=1. If ren|wen, capture addr/wdata/byte_en/ren/wen, load counter=LATENCY-1, and go to WAIT. If LATENCY=1, go directly to RESP.
- WAIT: busy=1. Each cycle, compare the live request against the captured one.
  - ren, wen, addr, byte_en, or wdata changed (including request dropped): abort. Go to IDLE with no write and no count. A still-present new request is accepted the next cycle from IDLE.
  - Otherwise decrement the counter; on reaching 0, go to RESP.
- RESP (exactly one cycle): busy=0.
  - Read: rdata = RAM[index] with byte_en ignored (full word; the initiator extends).
  - Write: RAM[index] lanes with byte_en=1 are updated at the end of this cycle; other lanes are kept.
  - Always returns to IDLE next cycle. Because busy is high in IDLE, the minimum request-to-request spacing is LATENCY+1 cycles.
- Simultaneous ren&wen: treated as a write. err pulses in RESP.
- Out-of-range: read returns OOR_RDATA, write is dropped, err pulses in RESP.
- Read-after-write to the same word in back-to-back transactions returns the new data; no bypass is needed given the IDLE gap.
- rdata holds its last RESP value outside RESP; write-only completions leave rdata unchanged.
- Counters increment in RESP only, including error completions. They saturate at 16'hFFFF.
- byte_en=0 on a write completes normally with no lanes changed; wr_count still increments.

Test Plan:
1. Reset, then write addr 0x10, wdata 0xDEADBEEF, byte_en 4'hF, LATENCY=2 → busy low exactly 2 cycles after the request edge, for one cycle; wr_count=1. Then read 0x10 → rdata=0xDEADBEEF in the busy-low cycle; rd_count=1.
2. Over word 0xDEADBEEF at 0x10, write wdata 0x11111111 with byte_en 4'b0100, then read 0x10 → rdata=0xDE11BEEF.
3. Read 0x0000_1000 with DEPTH=1024 → rdata=0xBAD0BAD0 and err=1 in the RESP cycle. A write to the same address leaves RAM word 0 unchanged.
4. Start a write to 0x20, change addr to 0x24 one cycle later → no write to 0x20. Busy-low occurs LATENCY cycles after the next IDLE acceptance of 0x24; wr_count increments by 1 total.
5. Assert RST in the WAIT cycle of a write to 0x30 → busy=1, counters=0, and a later read of 0x30 returns the pre-write value.
6. Hold ren with ren&wen=1 at 0x40, then sweep LATENCY ∈ {1,4,15} → write performed, err pulse, and busy-low cycle at exactly LATENCY cycles after acceptance in each case.

Source files
------------

// File: rtl/generic_bus_ram_responder_if.sv
// generic_bus_if: request/response bundle between a bus initiator
// (pipeline data port or fetch port) and a responder.
//
// Signals:
//   addr     byte address from the initiator
//   wdata    write data, lane-replicated by the initiator
//   ren/wen  read / write request, held until busy is seen low
//   byte_en  lane enables, bit i gates bits [8i+7:8i]
//   rdata    read data, valid only in the cycle busy is low
//   busy     high except for the single completion cycle
//   err      one-cycle pulse with an erroneous completion
interface generic_bus_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ren;
   logic        wen;
   logic [3:0]  byte_en;
   logic [31:0] rdata;
   logic        busy;
   logic        err;

   modport master (
      output addr, wdata, ren, wen, byte_en,
      input  rdata, busy, err
   );

   modport slave (
      input  addr, wdata, ren, wen, byte_en,
      output rdata, busy, err
   );
endinterface

// File: rtl/generic_bus_ram_responder.sv
// generic_bus_ram_responder: responder end of generic_bus_if backed by a
// word-organised, byte-writable RAM. A request is accepted in IDLE, held
// for LATENCY-1 WAIT cycles while the initiator must keep it stable, and
// completed in a single RESP cycle with busy low.
//
// Ports:
//   CLK       clock, all logic on the rising edge
//   RST       synchronous active-high reset (control state only; RAM kept)
//   bus       generic_bus_if slave modport (request in, rdata/busy/err out)
//   rd_count  completed reads, saturating at 16'hFFFF
//   wr_count  completed writes (including ren&wen), saturating
module generic_bus_ram_responder #(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned LATENCY   = 2,
   parameter logic [31:0] OOR_RDATA = 32'hBAD0_BAD0
) (
   input  logic         CLK,
   input  logic         RST,
   generic_bus_if.slave bus,
   output logic [15:0]  rd_count,
   output logic [15:0]  wr_count
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   // Any address bit above the word index makes the access out of range.
   function automatic logic is_oor(input logic [31:0] a);
      return |(a >> (AW + 2));
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

   logic [31:0] mem [DEPTH];

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        ren_q, ren_d;
   logic        wen_q, wen_d;
   logic [31:0] rdata_q, rdata_d;
   logic [15:0] rd_count_q, rd_count_d;
   logic [15:0] wr_count_q, wr_count_d;

   logic [AW-1:0] idx;
   logic          oor;
   logic          req_changed;
   logic          mem_we;
   logic [31:0]   mem_rd;
   logic [31:0]   wr_word;
   logic          busy_o;
   logic          err_o;
   logic [31:0]   rdata_o;

   assign idx     = addr_q[AW+1:2];
   assign oor     = is_oor(addr_q);
   assign mem_rd  = mem[idx];
   assign wr_word = merge_lanes(mem_rd, wdata_q, be_q);

   // The initiator must hold the whole request stable while we wait;
   // any difference (including a dropped request) cancels it.
   assign req_changed = (bus.ren != ren_q) || (bus.wen != wen_q) ||
                        (bus.addr != addr_q) || (bus.byte_en != be_q) ||
                        (bus.wdata != wdata_q);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      ren_d      = ren_q;
      wen_d      = wen_q;
      rdata_d    = rdata_q;
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      mem_we     = 1'b0;
      busy_o     = 1'b1;
      err_o      = 1'b0;
      rdata_o    = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (bus.ren || bus.wen) begin
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
               be_d    = bus.byte_en;
               ren_d   = bus.ren;
               wen_d   = bus.wen;
               cnt_d   = CNT_LOAD;
               state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
            end
         end

         S_WAIT: begin
            if (req_changed) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = S_RESP;
            end
         end

         S_RESP: begin
            busy_o  = 1'b0;
            state_d = S_IDLE;
            err_o   = oor || (ren_q && wen_q);
            // ren&wen is serviced as a write.
            if (wen_q) begin
               wr_count_d = sat_inc(wr_count_q);
               mem_we     = !oor;
            end else begin
               rd_count_d = sat_inc(rd_count_q);
               rdata_d    = oor ? OOR_RDATA : mem_rd;
               rdata_o    = rdata_d;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rdata_q    <= '0;
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   // Captured request: only meaningful outside IDLE, so no reset needed.
   always_ff @(posedge CLK) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
   end

   // Write commits at the end of RESP; a reset on that edge drops it.
   always_ff @(posedge CLK) begin
      if (mem_we && !RST) mem[idx] <= wr_word;
   end

   assign bus.busy  = busy_o;
   assign bus.err   = err_o;
   assign bus.rdata = rdata_o;
   assign rd_count  = rd_count_q;
   assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_generic_bus_ram_responder.sv
module tb_generic_bus_ram_responder;

   logic CLK;
   logic RST;

   generic_bus_if bus ();
   generic_bus_if bus1 ();
   generic_bus_if bus4 ();
   generic_bus_if bus15 ();

   logic [15:0] rd_count, wr_count;
   logic [15:0] rd1, wr1, rd4, wr4, rd15, wr15;

   // Shared request for the latency-sweep instances.
   logic        s_ren, s_wen;
   logic [31:0] s_addr, s_wdata;
   logic [3:0]  s_be;

   assign bus1.ren = s_ren;   assign bus1.wen = s_wen;   assign bus1.addr = s_addr;
   assign bus1.wdata = s_wdata;   assign bus1.byte_en = s_be;
   assign bus4.ren = s_ren;   assign bus4.wen = s_wen;   assign bus4.addr = s_addr;
   assign bus4.wdata = s_wdata;   assign bus4.byte_en = s_be;
   assign bus15.ren = s_ren;  assign bus15.wen = s_wen;  assign bus15.addr = s_addr;
   assign bus15.wdata = s_wdata;  assign bus15.byte_en = s_be;

   generic_bus_ram_responder #(.DEPTH(1024), .LATENCY(2), .OOR_RDATA(32'hBAD0_BAD0)) dut (
      .CLK(CLK), .RST(RST), .bus(bus), .rd_count(rd_count), .wr_count(wr_count)
   );
   generic_bus_ram_responder #(.DEPTH(1024), .LATENCY(1), .OOR_RDATA(32'hBAD0_BAD0)) dut_l1 (
      .CLK(CLK), .RST(RST), .bus(bus1), .rd_count(rd1), .wr_count(wr1)
   );
   generic_bus_ram_responder #(.DEPTH(1024), .LATENCY(4), .OOR_RDATA(32'hBAD0_BAD0)) dut_l4 (
      .CLK(CLK), .RST(RST), .bus(bus4), .rd_count(rd4), .wr_count(wr4)
   );
   generic_bus_ram_responder #(.DEPTH(1024), .LATENCY(15), .OOR_RDATA(32'hBAD0_BAD0)) dut_l15 (
      .CLK(CLK), .RST(RST), .bus(bus15), .rd_count(rd15), .wr_count(wr15)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [16];

   // Drive one request on the main bus, wait for busy low (bounded),
   // then hold through the completion edge and drop the request.
   task automatic do_txn(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         output int lat, output logic [31:0] rd, output logic er);
      bit got;
      bus.ren = r; bus.wen = w; bus.addr = a; bus.wdata = d; bus.byte_en = be;
      got = 0; lat = 0; rd = '0; er = 1'b0;
      for (int i = 1; i <= 40 && !got; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (bus.busy == 1'b0) begin
            got = 1; lat = i; rd = bus.rdata; er = bus.err;
         end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL txn_timeout: got busy=1 expected busy=0 within 40 cycles");
      end
      @(posedge CLK);
      #1;
      bus.ren = 1'b0; bus.wen = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        er;
      int          exp_rd, exp_wr;
      int          lat_s [3];
      logic        err_s [3];
      logic [31:0] rd_s  [3];
      bit          seen  [3];
      bit          all_seen;

      vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0000_0000};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1111_1111, 4'h4, 1'b0, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'hDE11_BEEF};
      vecs[4]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1'b0, 32'hDE11_BEEF};
      vecs[5]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         4'hF, 1'b1, 32'hBAD0_BAD0};
      vecs[6]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 1'b1, 32'hBAD0_BAD0};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b0, 32'hCAFE_F00D};
      vecs[8]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'hCAFE_F00D};
      vecs[9]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         4'h0, 1'b0, 32'hDE11_BEEF};
      vecs[10] = '{1'b1, 1'b1, 32'h0000_0044, 32'h5A5A_5A5A, 4'hF, 1'b1, 32'hDE11_BEEF};
      vecs[11] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         4'hF, 1'b0, 32'h5A5A_5A5A};
      vecs[12] = '{1'b0, 1'b1, 32'h0000_0014, 32'h0000_0000, 4'hF, 1'b0, 32'h5A5A_5A5A};
      vecs[13] = '{1'b0, 1'b1, 32'h0000_0014, 32'hAABB_CCDD, 4'h9, 1'b0, 32'h5A5A_5A5A};
      vecs[14] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,         4'hF, 1'b0, 32'hAA00_00DD};
      vecs[15] = '{1'b1, 1'b0, 32'h8000_0010, 32'h0,         4'hF, 1'b1, 32'hBAD0_BAD0};

      RST = 1'b1;
      bus.ren = 1'b0; bus.wen = 1'b0; bus.addr = '0; bus.wdata = '0; bus.byte_en = '0;
      s_ren = 1'b0; s_wen = 1'b0; s_addr = '0; s_wdata = '0; s_be = '0;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      check("reset_busy", 32'(bus.busy), 32'd1);
      check("reset_rdata", bus.rdata, 32'h0);
      check("reset_err", 32'(bus.err), 32'd0);
      check("reset_rd_count", 32'(rd_count), 32'd0);
      check("reset_wr_count", 32'(wr_count), 32'd0);

      exp_rd = 0; exp_wr = 0;
      for (int v = 0; v < 16; v++) begin
         do_txn(vecs[v].ren, vecs[v].wen, vecs[v].addr, vecs[v].wdata, vecs[v].be, lat, rd, er);
         if (vecs[v].wen) exp_wr++; else exp_rd++;
         check($sformatf("vec%0d_latency", v), 32'(lat), 32'd2);
         check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
         check($sformatf("vec%0d_err", v), 32'(er), 32'(vecs[v].exp_err));
         check($sformatf("vec%0d_rd_count", v), 32'(rd_count), 32'(exp_rd));
         check($sformatf("vec%0d_wr_count", v), 32'(wr_count), 32'(exp_wr));
      end

      // Aborted write: address changes during WAIT, new request accepted later.
      do_txn(1'b0, 1'b1, 32'h20, 32'h0000_0020, 4'hF, lat, rd, er);
      exp_wr++;
      bus.ren = 1'b0; bus.wen = 1'b1; bus.addr = 32'h20; bus.wdata = 32'h9999_9999; bus.byte_en = 4'hF;
      @(posedge CLK);
      #1 bus.addr = 32'h24;
      lat = 0;
      for (int i = 1; i <= 40 && lat == 0; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (bus.busy == 1'b0) lat = i;
      end
      check("abort_latency", 32'(lat), 32'd3);
      @(posedge CLK);
      #1 bus.wen = 1'b0;
      exp_wr++;
      check("abort_wr_count", 32'(wr_count), 32'(exp_wr));
      do_txn(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, lat, rd, er);
      check("abort_old_addr_kept", rd, 32'h0000_0020);
      do_txn(1'b1, 1'b0, 32'h24, 32'h0, 4'hF, lat, rd, er);
      check("abort_new_addr_written", rd, 32'h9999_9999);

      // Reset during WAIT of a write cancels it.
      do_txn(1'b0, 1'b1, 32'h30, 32'h3030_3030, 4'hF, lat, rd, er);
      bus.ren = 1'b0; bus.wen = 1'b1; bus.addr = 32'h30; bus.wdata = 32'hFFFF_0000; bus.byte_en = 4'hF;
      @(posedge CLK);
      #1 RST = 1'b1; bus.wen = 1'b0;
      @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      check("rst_wait_busy", 32'(bus.busy), 32'd1);
      check("rst_wait_rd_count", 32'(rd_count), 32'd0);
      check("rst_wait_wr_count", 32'(wr_count), 32'd0);
      check("rst_wait_rdata", bus.rdata, 32'h0);
      do_txn(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, lat, rd, er);
      check("rst_wait_no_write", rd, 32'h3030_3030);
      check("rst_wait_read_count", 32'(rd_count), 32'd1);

      // Latency sweep with ren&wen held at 0x40 on LATENCY 1/4/15 instances.
      @(posedge CLK);
      #1;
      s_ren = 1'b1; s_wen = 1'b1; s_addr = 32'h40; s_wdata = 32'h0BAD_F00D; s_be = 4'hF;
      for (int k = 0; k < 3; k++) begin seen[k] = 0; lat_s[k] = 0; err_s[k] = 0; end
      all_seen = 0;
      for (int i = 1; i <= 40 && !all_seen; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (!seen[0] && !bus1.busy)  begin seen[0] = 1; lat_s[0] = i; err_s[0] = bus1.err;  end
         if (!seen[1] && !bus4.busy)  begin seen[1] = 1; lat_s[1] = i; err_s[1] = bus4.err;  end
         if (!seen[2] && !bus15.busy) begin seen[2] = 1; lat_s[2] = i; err_s[2] = bus15.err; end
         all_seen = seen[0] && seen[1] && seen[2];
      end
      check("sweep_l1_latency", 32'(lat_s[0]), 32'd1);
      check("sweep_l4_latency", 32'(lat_s[1]), 32'd4);
      check("sweep_l15_latency", 32'(lat_s[2]), 32'd15);
      check("sweep_l1_err", 32'(err_s[0]), 32'd1);
      check("sweep_l4_err", 32'(err_s[1]), 32'd1);
      check("sweep_l15_err", 32'(err_s[2]), 32'd1);
      @(posedge CLK);
      #1 s_ren = 1'b0; s_wen = 1'b0;
      repeat (2) @(posedge CLK);
      #1 s_ren = 1'b1; s_wen = 1'b0;
      for (int k = 0; k < 3; k++) begin seen[k] = 0; lat_s[k] = 0; rd_s[k] = '0; end
      all_seen = 0;
      for (int i = 1; i <= 40 && !all_seen; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (!seen[0] && !bus1.busy)  begin seen[0] = 1; lat_s[0] = i; rd_s[0] = bus1.rdata;  end
         if (!seen[1] && !bus4.busy)  begin seen[1] = 1; lat_s[1] = i; rd_s[1] = bus4.rdata;  end
         if (!seen[2] && !bus15.busy) begin seen[2] = 1; lat_s[2] = i; rd_s[2] = bus15.rdata; end
         all_seen = seen[0] && seen[1] && seen[2];
      end
      check("sweep_l1_readback", rd_s[0], 32'h0BAD_F00D);
      check("sweep_l4_readback", rd_s[1], 32'h0BAD_F00D);
      check("sweep_l15_readback", rd_s[2], 32'h0BAD_F00D);
      check("sweep_l15_read_latency", 32'(lat_s[2]), 32'd15);
      @(posedge CLK);
      #1 s_ren = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
